mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (data load/store) of the 5-stage pipeline.
- Sequences one memory transaction at a time through a valid/ready request channel and an rvalid response channel.
- Returns read data and a one-cycle done pulse to the winning requester.
- Drives per-stage stall signals that the pipeline uses to freeze IF/ID and EX/MEM.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/arb_starve_ctr.sv | 37 +++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline memory-port arbiter.
package pipe_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Priority decision between IF and DM with a saturating starvation counter:
// DM normally wins ties, but after STARVE_MAX consecutive tie losses IF wins once.
module arb_starve_ctr #(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic dm_req,
    input  logic grant_en,
    output logic grant_if,
    output logic grant_dm
);

    logic [3:0] r_starve_cnt;
    logic       w_if_prio;

    assign w_if_prio = (r_starve_cnt == 4'(STARVE_MAX));

    // Grant decision: a lone requester wins; on a tie DM wins unless IF is starved.
    always_comb begin
        grant_if = grant_en & if_req & (~dm_req | w_if_prio);
        grant_dm = grant_en & dm_req & ~grant_if;
    end

    // Count DM grants that made IF wait; any IF grant clears the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (grant_if) begin
            r_starve_cnt <= '0;
        end else if (grant_dm && if_req && !w_if_prio) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the IF and MEM pipeline stages,
// running one valid/ready request plus rvalid response at a time.
module mem_port_arbiter
    import pipe_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        r_state;
    owner_t            r_owner;
    logic              r_mem_valid;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_if_done;
    logic              r_dm_done;

    logic              w_grant_en;
    logic              w_grant_if;
    logic              w_grant_dm;

    // No arbitration in the done cycle: the finishing stage's req is still its
    // old request, so the next grant waits for the following cycle's req values.
    assign w_grant_en = (r_state == ST_IDLE) & ~r_if_done & ~r_dm_done;

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk      (clk),
        .rst_n    (reset),
        .if_req   (if_req),
        .dm_req   (dm_req),
        .grant_en (w_grant_en),
        .grant_if (w_grant_if),
        .grant_dm (w_grant_dm)
    );

    // Transaction sequencer: grant and latch payload, hold until accepted, await response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_IF;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_done   <= 1'b0;
            r_dm_done   <= 1'b0;
        end else begin
            r_if_done <= 1'b0;
            r_dm_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_if || w_grant_dm) begin
                        r_owner     <= w_grant_if ? OWN_IF : OWN_DM;
                        r_mem_addr  <= w_grant_if ? if_addr : dm_addr;
                        r_mem_we    <= w_grant_dm & dm_we;
                        r_mem_wdata <= w_grant_if ? '0 : dm_wdata;
                        r_mem_valid <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= ST_WAIT_RSP;
                    end
                end
                ST_WAIT_RSP: begin
                    if (mem_rvalid) begin
                        if (r_owner == OWN_IF) begin
                            r_if_rdata <= mem_rdata;
                            r_if_done  <= 1'b1;
                        end else begin
                            if (!r_mem_we) begin
                                r_dm_rdata <= mem_rdata;
                            end
                            r_dm_done <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_valid = r_mem_valid;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign if_done   = r_if_done;
    assign dm_done   = r_dm_done;

    // Stalls are combinational so the pipeline freezes in the same cycle.
    assign stall_if  = if_req & ~r_if_done;
    assign stall_mem = dm_req & ~r_dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_done    (if_done),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata),
        .dm_done    (dm_done),
        .stall_if   (stall_if),
        .stall_mem  (stall_mem),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 0;
        tick(); tick();
        reset = 1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 0;
        tick(); tick();
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b expected 0", mem_valid); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
        checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", if_rdata, dm_rdata); end
        checks++; if (if_done !== 1'b0 || dm_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b/%b expected 0/0", if_done, dm_done); end
        reset = 1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_single_fetch();
        if_req = 1; if_addr = 32'h40; mem_ready = 1;
        #1;
        checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL fetch_stall_c0: got %b expected 1", stall_if); end
        tick();
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin errors++; $display("FAIL fetch_issue: got v=%b a=%h we=%b expected v=1 a=40 we=0", mem_valid, mem_addr, mem_we); end
        checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL fetch_stall_c1: got %b expected 1", stall_if); end
        tick();
        checks++; if (mem_valid !== 1'b0 || if_done !== 1'b0) begin errors++; $display("FAIL fetch_accept: got v=%b done=%b expected 0/0", mem_valid, if_done); end
        checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL fetch_stall_c2: got %b expected 1", stall_if); end
        mem_rvalid = 1; mem_rdata = 32'h8C220004;
        tick();
        checks++; if (if_done !== 1'b1 || if_rdata !== 32'h8C220004) begin errors++; $display("FAIL fetch_done: got done=%b rdata=%h expected 1/8c220004", if_done, if_rdata); end
        checks++; if (stall_if !== 1'b0 || dm_done !== 1'b0) begin errors++; $display("FAIL fetch_stall_c3: got stall=%b dm_done=%b expected 0/0", stall_if, dm_done); end
        if_req = 0; mem_rvalid = 0; mem_ready = 0;
        tick();
        checks++; if (if_done !== 1'b0 || if_rdata !== 32'h8C220004) begin errors++; $display("FAIL fetch_hold: got done=%b rdata=%h expected 0/8c220004", if_done, if_rdata); end
        $display("test_single_fetch done");
    endtask

    task automatic test_contention();
        logic exp_if;
        apply_reset();
        if_req = 1; if_addr = 32'h200;
        dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF;
        for (int g = 0; g < 5; g++) begin
            exp_if = (g == 3);
            for (int k = 0; k < 20 && !mem_valid; k++) tick();
            checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL contention_grant_timeout g=%0d: got valid=%b expected 1", g, mem_valid); end
            if (exp_if) begin
                checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h200) begin errors++; $display("FAIL contention_if_payload g=%0d: got we=%b a=%h expected 0/200", g, mem_we, mem_addr); end
            end else begin
                checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL contention_dm_payload g=%0d: got we=%b a=%h d=%h expected 1/100/deadbeef", g, mem_we, mem_addr, mem_wdata); end
            end
            mem_ready = 1;
            tick();
            mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hA0000000 + 32'(g);
            tick();
            mem_rvalid = 0;
            checks++; if (if_done !== exp_if || dm_done !== !exp_if) begin errors++; $display("FAIL contention_done g=%0d: got if=%b dm=%b expected if=%b dm=%b", g, if_done, dm_done, exp_if, !exp_if); end
            if (g == 4) begin if_req = 0; dm_req = 0; end
        end
        checks++; if (if_rdata !== 32'hA0000003 || dm_rdata !== 32'h0) begin errors++; $display("FAIL contention_rdata: got if=%h dm=%h expected a0000003/0", if_rdata, dm_rdata); end
        tick(); tick();
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL contention_idle: got valid=%b expected 0", mem_valid); end
        $display("test_contention done");
    endtask

    task automatic test_backpressure();
        int done_cnt;
        dm_req = 1; dm_we = 0; dm_addr = 32'h300; dm_wdata = 32'h0;
        tick();
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h300) begin errors++; $display("FAIL bp_issue: got v=%b a=%h expected 1/300", mem_valid, mem_addr); end
        dm_addr = 32'h777;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h300 || mem_we !== 1'b0) begin errors++; $display("FAIL bp_hold c=%0d: got v=%b a=%h we=%b expected 1/300/0", c, mem_valid, mem_addr, mem_we); end
        end
        mem_ready = 1;
        tick();
        mem_ready = 0;
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL bp_accept: got v=%b expected 0", mem_valid); end
        mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_rvalid = 0;
        checks++; if (dm_done !== 1'b1 || dm_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL bp_done: got done=%b rdata=%h expected 1/cafef00d", dm_done, dm_rdata); end
        dm_req = 0;
        done_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (dm_done === 1'b1 || mem_valid === 1'b1) done_cnt++;
        end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL bp_single_txn: got %0d extra cycles of activity expected 0", done_cnt); end
        $display("test_backpressure done");
    endtask

    task automatic test_stray_response();
        mem_rvalid = 1; mem_rdata = 32'h12345678; mem_ready = 1;
        tick(); tick();
        checks++; if (if_done !== 1'b0 || dm_done !== 1'b0) begin errors++; $display("FAIL stray_done: got %b/%b expected 0/0", if_done, dm_done); end
        checks++; if (if_rdata !== 32'hA0000003 || dm_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL stray_rdata: got %h/%h expected a0000003/cafef00d", if_rdata, dm_rdata); end
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL stray_valid: got %b expected 0", mem_valid); end
        mem_rvalid = 0; mem_ready = 0;
        tick();
        $display("test_stray_response done");
    endtask

    task automatic test_reset_mid_op();
        if_req = 1; if_addr = 32'h80;
        tick();
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h80) begin errors++; $display("FAIL rmid_issue: got v=%b a=%h expected 1/80", mem_valid, mem_addr); end
        mem_ready = 1;
        tick();
        mem_ready = 0;
        reset = 0; if_req = 0; mem_rvalid = 1; mem_rdata = 32'hDEAD0001;
        #1;
        checks++; if (mem_valid !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL rmid_async_req: got v=%b a=%h expected 0/0", mem_valid, mem_addr); end
        checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin errors++; $display("FAIL rmid_async_rdata: got %h/%h expected 0/0", if_rdata, dm_rdata); end
        checks++; if (if_done !== 1'b0 || dm_done !== 1'b0) begin errors++; $display("FAIL rmid_async_done: got %b/%b expected 0/0", if_done, dm_done); end
        tick();
        reset = 1;
        tick();
        checks++; if (if_done !== 1'b0 || if_rdata !== 32'h0) begin errors++; $display("FAIL rmid_late_rsp: got done=%b rdata=%h expected 0/0", if_done, if_rdata); end
        mem_rvalid = 0;
        if_req = 1; if_addr = 32'h0;
        tick();
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h0 || mem_we !== 1'b0) begin errors++; $display("FAIL rmid_refetch_issue: got v=%b a=%h we=%b expected 1/0/0", mem_valid, mem_addr, mem_we); end
        mem_ready = 1;
        tick();
        mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h11111111;
        tick();
        mem_rvalid = 0;
        checks++; if (if_done !== 1'b1 || if_rdata !== 32'h11111111) begin errors++; $display("FAIL rmid_refetch_done: got done=%b rdata=%h expected 1/11111111", if_done, if_rdata); end
        if_req = 0;
        tick();
        $display("test_reset_mid_op done");
    endtask

    task automatic test_withdrawn();
        dm_req = 1; dm_we = 0; dm_addr = 32'h500;
        tick();
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h500) begin errors++; $display("FAIL wd_issue: got v=%b a=%h expected 1/500", mem_valid, mem_addr); end
        dm_req = 0; dm_addr = 32'h999;
        #1;
        checks++; if (stall_mem !== 1'b0) begin errors++; $display("FAIL wd_stall: got %b expected 0", stall_mem); end
        mem_ready = 1;
        tick();
        mem_ready = 0;
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL wd_accept: got v=%b expected 0", mem_valid); end
        mem_rvalid = 1; mem_rdata = 32'h55AA55AA;
        tick();
        mem_rvalid = 0;
        checks++; if (dm_done !== 1'b1 || dm_rdata !== 32'h55AA55AA) begin errors++; $display("FAIL wd_done: got done=%b rdata=%h expected 1/55aa55aa", dm_done, dm_rdata); end
        tick();
        checks++; if (dm_done !== 1'b0 || mem_valid !== 1'b0) begin errors++; $display("FAIL wd_after: got done=%b v=%b expected 0/0", dm_done, mem_valid); end
        $display("test_withdrawn done");
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_backpressure();
        test_stray_response();
        test_reset_mid_op();
        test_withdrawn();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
